// File: rtl/sequenciador_programa_pkg.sv
// Shared constants for the instruction sequencer: opcodes, FSM encoding and
// the watchdog limit.
package sequenciador_programa_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [2:0] WATCHDOG_MAX = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_IMM   = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  function automatic logic [2:0] opcode_of(input logic [8:0] instr);
    return instr[8:6];
  endfunction

endpackage

// File: rtl/sequenciador_programa_memoria.sv
// Program memory: register array with synchronous write and two asynchronous
// read ports (instruction word and the word after it, for mvi immediates).
module memoria_programa #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/sequenciador_programa.sv
// Instruction issuer for the DIN/Run/Done handshake of the multicycle processor:
// walks the program memory, supplies mvi immediates and guards with a watchdog.
module sequenciador_programa #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Prog_we,
  input  logic [ADDR_W-1:0] Prog_addr,
  input  logic [DATA_W-1:0] Prog_data,
  input  logic [ADDR_W:0]   Prog_len,
  input  logic              Done,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic [ADDR_W:0]   PC,
  output logic [7:0]        Instr_count,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);
  import sequenciador_programa_pkg::*;

  // state   | meaning
  // S_IDLE  | after reset, waiting for Start
  // S_ISSUE | instruction word mem[PC] on DIN, Run high
  // S_IMM   | mvi immediate mem[PC+1] on DIN
  // S_WAIT  | holding last word until Done or watchdog expiry
  // S_HALT  | program finished, waiting for Start
  // S_ERROR | watchdog expiry or truncated immediate

  localparam logic [2:0] WDOG_LAST = WATCHDOG_MAX - 3'd1;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   pc, pc_nxt, len, len_nxt, pc_inc1, pc_step;
  logic [7:0]        count, count_nxt;
  logic [2:0]        wdog, wdog_nxt;
  logic [DATA_W-1:0] din_hold, din_hold_nxt;
  logic [DATA_W-1:0] word_pc, word_imm;
  logic              is_mvi, mem_we, stopped;

  assign stopped = (state == S_IDLE) || (state == S_HALT) || (state == S_ERROR);
  assign mem_we  = Prog_we && stopped;
  assign pc_inc1 = pc + (ADDR_W+1)'(1);
  assign is_mvi  = opcode_of(word_pc[8:0]) == OP_MVI;
  assign pc_step = is_mvi ? pc + (ADDR_W+1)'(2) : pc_inc1;

  memoria_programa #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clock     (Clock),
    .we        (mem_we),
    .wr_addr   (Prog_addr),
    .wr_data   (Prog_data),
    .rd_addr_a (pc[ADDR_W-1:0]),
    .rd_addr_b (pc_inc1[ADDR_W-1:0]),
    .rd_data_a (word_pc),
    .rd_data_b (word_imm)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      len      <= '0;
      count    <= '0;
      wdog     <= '0;
      din_hold <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      len      <= len_nxt;
      count    <= count_nxt;
      wdog     <= wdog_nxt;
      din_hold <= din_hold_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    len_nxt      = len;
    count_nxt    = count;
    wdog_nxt     = wdog;
    din_hold_nxt = din_hold;
    case (state)
      S_IDLE, S_HALT, S_ERROR: begin
        if (Start) begin
          pc_nxt  = '0;
          len_nxt = Prog_len;
          if (state == S_ERROR) count_nxt = '0;
          state_nxt = (Prog_len == '0) ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Done is not looked at here: the processor never completes in T0.
        wdog_nxt     = '0;
        din_hold_nxt = word_pc;
        if (is_mvi && (pc_inc1 >= len)) state_nxt = S_ERROR;
        else if (is_mvi)                state_nxt = S_IMM;
        else                            state_nxt = S_WAIT;
      end
      S_IMM, S_WAIT: begin
        if (state == S_IMM) din_hold_nxt = word_imm;
        if (Done) begin
          count_nxt = count + 8'd1;
          pc_nxt    = pc_step;
          state_nxt = (pc_step >= len) ? S_HALT : S_ISSUE;
        end else if (wdog == WDOG_LAST) begin
          state_nxt = S_ERROR;
        end else begin
          wdog_nxt = wdog + 3'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (state)
      S_ISSUE: DIN = word_pc;
      S_IMM:   DIN = word_imm;
      S_WAIT:  DIN = din_hold;
      default: DIN = '0;
    endcase
  end

  assign Busy        = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
  assign Run         = Busy;
  assign Halted      = state == S_HALT;
  assign Error       = state == S_ERROR;
  assign PC          = pc;
  assign Instr_count = count;

endmodule

// File: tb/tb_sequenciador_programa.sv
// Directed bench for sequenciador_programa with a small processor model that
// answers Done and executes mv/mvi/add/sub on its own register file.
module tb_sequenciador_programa;

  logic        Clock = 1'b0;
  logic        Reset, Start, Prog_we, Done;
  logic [4:0]  Prog_addr;
  logic [15:0] Prog_data;
  logic [5:0]  Prog_len;
  logic [15:0] DIN;
  logic        Run, Busy, Halted, Error;
  logic [5:0]  PC;
  logic [7:0]  Instr_count;

  int n_assert = 0;
  int n_fail   = 0;

  // processor model
  logic        proc_en;
  logic [1:0]  t;
  logic [15:0] ir;
  logic [15:0] r [8];
  logic        model_done;

  always #5 Clock = ~Clock;

  sequenciador_programa dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Prog_we     (Prog_we),
    .Prog_addr   (Prog_addr),
    .Prog_data   (Prog_data),
    .Prog_len    (Prog_len),
    .Done        (Done),
    .DIN         (DIN),
    .Run         (Run),
    .PC          (PC),
    .Instr_count (Instr_count),
    .Busy        (Busy),
    .Halted      (Halted),
    .Error       (Error)
  );

  assign model_done = Run && t != 2'd0 &&
    ((t == 2'd1 && (ir[8:6] == 3'b000 || ir[8:6] == 3'b001)) ||
     (t == 2'd3 && (ir[8:6] == 3'b010 || ir[8:6] == 3'b011)));
  assign Done = proc_en && model_done;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) t <= 2'd0;
    else if (!Run) t <= 2'd0;
    else if (proc_en) begin
      if (t == 2'd0) begin
        ir <= DIN;
        t  <= 2'd1;
      end else if (model_done) begin
        case (ir[8:6])
          3'b000:  r[ir[5:3]] <= r[ir[2:0]];
          3'b001:  r[ir[5:3]] <= DIN;
          3'b010:  r[ir[5:3]] <= r[ir[5:3]] + r[ir[2:0]];
          default: r[ir[5:3]] <= r[ir[5:3]] - r[ir[2:0]];
        endcase
        t <= 2'd0;
      end else t <= t + 2'd1;
    end
  end

  task automatic tick;
    @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [4:0] a, input logic [15:0] d);
    Prog_we = 1'b1; Prog_addr = a; Prog_data = d;
    tick();
    Prog_we = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!Halted && n < 40) begin
      tick();
      n++;
    end
    check(tag, Halted, 1);
  endtask

  task automatic start_prog(input logic [5:0] l);
    Start = 1'b1; Prog_len = l;
    tick();
    Start = 1'b0;
  endtask

  task automatic pulse_reset;
    #2 Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Prog_we = 1'b0; Prog_addr = '0;
    Prog_data = '0; Prog_len = '0; proc_en = 1'b0;
    tick(); tick();
    check("rst_din", DIN, 0);
    check("rst_run", Run, 0);
    check("rst_pc", PC, 0);
    check("rst_cnt", Instr_count, 0);
    check("rst_flags", {Busy, Halted, Error}, 0);
    Reset = 1'b0;
    tick();

    // add program: mvi R0,5; mvi R1,3; add R0,R1
    write_word(5'd0, 16'h0040);
    write_word(5'd1, 16'h0005);
    write_word(5'd2, 16'h0048);
    write_word(5'd3, 16'h0003);
    write_word(5'd4, 16'h0081);
    proc_en = 1'b1;
    start_prog(6'd5);
    check("add_issue_din", DIN, 16'h0040);
    check("add_issue_run", Run, 1);
    tick();
    check("add_imm_din", DIN, 16'h0005);
    tick();
    check("add_next_din", DIN, 16'h0048);
    check("add_next_pc", PC, 2);
    check("add_next_cnt", Instr_count, 1);
    check("add_no_bubble", Run, 1);
    wait_halt("add_halt");
    check("add_cnt", Instr_count, 3);
    check("add_pc", PC, 5);
    check("add_r0", r[0], 16'h0008);
    check("add_halt_run", Run, 0);
    check("add_halt_din", DIN, 0);

    // mvi timing, then watchdog on a mv that never completes
    write_word(5'd1, 16'h1234);
    write_word(5'd2, 16'h0001);
    start_prog(6'd3);
    check("mvi_issue_din", DIN, 16'h0040);
    check("mvi_issue_run", Run, 1);
    tick();
    check("mvi_imm_din", DIN, 16'h1234);
    check("mvi_imm_run", Run, 1);
    tick();
    proc_en = 1'b0;
    check("wd_issue_din", DIN, 16'h0001);
    check("wd_issue_cnt", Instr_count, 4);
    for (int i = 0; i < 7; i++) tick();
    check("wd_7th_err", Error, 0);
    check("wd_7th_run", Run, 1);
    tick();
    check("wd_err", Error, 1);
    check("wd_err_run", Run, 0);
    check("wd_err_busy", Busy, 0);

    // restart from ERROR into a truncated mvi (len 1)
    start_prog(6'd1);
    check("trunc_err_clr", Error, 0);
    check("trunc_cnt_zero", Instr_count, 0);
    check("trunc_issue_din", DIN, 16'h0040);
    check("trunc_issue_pc", PC, 0);
    tick();
    check("trunc_err", Error, 1);
    check("trunc_cnt", Instr_count, 0);
    check("trunc_run", Run, 0);

    // reset while waiting
    start_prog(6'd3);
    tick();
    tick();
    check("mid_wait_din", DIN, 16'h1234);
    check("mid_wait_busy", Busy, 1);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_outs", {DIN, Run, Busy, Halted, Error}, 0);
    check("mid_rst_pc", PC, 0);
    check("mid_rst_cnt", Instr_count, 0);
    tick();
    Reset = 1'b0;
    proc_en = 1'b1;
    start_prog(6'd3);
    check("rerun_issue_din", DIN, 16'h0040);
    tick();
    check("rerun_imm_din", DIN, 16'h1234);
    tick();
    check("rerun_mv_din", DIN, 16'h0001);
    wait_halt("rerun_halt");
    check("rerun_cnt", Instr_count, 2);
    check("rerun_pc", PC, 3);
    check("rerun_r0", r[0], 16'h0003);

    // write and Start while busy are ignored
    proc_en = 1'b0;
    start_prog(6'd3);
    Prog_we = 1'b1; Prog_addr = 5'd2; Prog_data = 16'hFFFF;
    Start = 1'b1; Prog_len = 6'd5;
    tick();
    Prog_we = 1'b0; Start = 1'b0;
    check("busy_pc", PC, 0);
    check("busy_wait_din", DIN, 16'h1234);
    check("busy_busy", Busy, 1);
    pulse_reset();
    proc_en = 1'b1;
    start_prog(6'd3);
    tick();
    tick();
    check("busy_mem2_kept", DIN, 16'h0001);
    wait_halt("busy_halt");

    // zero-length program goes straight to HALT
    pulse_reset();
    start_prog(6'd0);
    check("len0_halt", Halted, 1);
    check("len0_run", Run, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
